// File: rtl/vga_pkg.sv
// Shared constants and arbiter state encoding for the VGA framebuffer path.
package vga_pkg;

  localparam int ADDR_W       = 18;
  localparam int VGA_FB_WORDS = 153600;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISP_RD = 2'd1,
    ST_WR      = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_word_fifo.sv
// Display prefetch FIFO: synchronous, power-of-two depth, occupancy count and flush.
module vga_word_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              CLK_50M,
  input  logic              FPGA_nRST,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CW-1:0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK_50M or negedge FPGA_nRST) begin
    if (!FPGA_nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge CLK_50M) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display prefetch reads vs. drawing-port writes,
// plus the byte-serialising pixel output stage.
module vga_fb_arbiter import vga_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int URGENT_LVL = 4,
  parameter int FB_WORDS   = VGA_FB_WORDS
) (
  input  logic              CLK_50M,
  input  logic              FPGA_nRST,
  input  logic              Pix_CE,
  input  logic [9:0]        HS_Count,
  input  logic [9:0]        VS_Count,
  input  logic              Data_valid,
  input  logic              Wr_Req,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [15:0]       Wr_Data,
  output logic              Wr_Ack,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [15:0]       Mem_WData,
  input  logic [15:0]       Mem_RData,
  output logic [7:0]        Pixel_Out,
  output logic              Pixel_Valid,
  output logic              Underflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  arb_state_t        state_q;
  logic [ADDR_W-1:0] disp_addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              rvalid_q;
  logic              phase_q;
  logic [7:0]        pix_q;
  logic              pix_vld_q;
  logic              uflow_q;

  logic [CW-1:0] fifo_cnt;
  logic [15:0]   fifo_head;
  logic [CW:0]   occ;
  logic          frame_start;
  logic          rd_on_bus;
  logic          disp_ok;
  logic          urgent;
  logic          wr_pend;
  logic          pix_due;
  logic          fifo_pop;

  assign frame_start = Pix_CE && (HS_Count == 10'd0) && (VS_Count == 10'd0);
  assign rd_on_bus   = (state_q == ST_DISP_RD);

  // Up to two reads can be outstanding: one on the bus, one returning data.
  assign occ     = (CW+1)'(fifo_cnt) + (CW+1)'(rd_on_bus) + (CW+1)'(rvalid_q);
  assign disp_ok = !frame_start && (occ < (CW+1)'(FIFO_DEPTH)) &&
                   ({1'b0, disp_addr_q} < (ADDR_W+1)'(FB_WORDS));
  assign urgent  = occ < (CW+1)'(URGENT_LVL);
  // A request still high during its own ack cycle has already been served.
  assign wr_pend = Wr_Req && !Wr_Ack;

  assign Mem_En    = (state_q != ST_IDLE);
  assign Mem_We    = (state_q == ST_WR);
  assign Wr_Ack    = (state_q == ST_WR);
  assign Mem_Addr  = mem_addr_q;
  assign Mem_WData = mem_wdata_q;

  always_ff @(posedge CLK_50M or negedge FPGA_nRST) begin
    if (!FPGA_nRST) begin
      state_q     <= ST_IDLE;
      disp_addr_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_on_bus && !frame_start;
      if (frame_start) disp_addr_q <= '0;
      if (disp_ok && urgent) begin
        state_q     <= ST_DISP_RD;
        mem_addr_q  <= disp_addr_q;
        disp_addr_q <= disp_addr_q + ADDR_W'(1);
      end else if (wr_pend) begin
        state_q     <= ST_WR;
        mem_addr_q  <= Wr_Addr;
        mem_wdata_q <= Wr_Data;
      end else if (disp_ok) begin
        state_q     <= ST_DISP_RD;
        mem_addr_q  <= disp_addr_q;
        disp_addr_q <= disp_addr_q + ADDR_W'(1);
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign pix_due  = Pix_CE && Data_valid && !frame_start;
  assign fifo_pop = pix_due && (fifo_cnt != '0) && phase_q;

  vga_word_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (16),
    .CW     (CW)
  ) u_fifo (
    .CLK_50M   (CLK_50M),
    .FPGA_nRST (FPGA_nRST),
    .flush_i   (frame_start),
    .push_i    (rvalid_q),
    .wdata_i   (Mem_RData),
    .pop_i     (fifo_pop),
    .rdata_o   (fifo_head),
    .count_o   (fifo_cnt)
  );

  // Frame start takes precedence over a pixel strobe on the same cycle.
  always_ff @(posedge CLK_50M or negedge FPGA_nRST) begin
    if (!FPGA_nRST) begin
      pix_q     <= 8'h00;
      pix_vld_q <= 1'b0;
      uflow_q   <= 1'b0;
      phase_q   <= 1'b0;
    end else begin
      pix_vld_q <= 1'b0;
      if (frame_start) begin
        phase_q <= 1'b0;
        uflow_q <= 1'b0;
      end else if (pix_due) begin
        pix_vld_q <= 1'b1;
        if (fifo_cnt == '0) begin
          pix_q   <= 8'h00;
          uflow_q <= 1'b1;
        end else begin
          pix_q   <= phase_q ? fifo_head[15:8] : fifo_head[7:0];
          phase_q <= !phase_q;
        end
      end
    end
  end

  assign Pixel_Out   = pix_q;
  assign Pixel_Valid = pix_vld_q;
  assign Underflow   = uflow_q;

endmodule
